mem_access_unit: RTL and testbench

- Pipeline-side initiator for the data RAM: takes one load/store request per handshake from the MEM stage and drives the RAM's ce/we/addr/sel/data port.
- Handles all MIPS32 load/store widths, including lwl/lwr/swl/swr:
  - byte-lane steering for stores (big-endian);
  - extraction, sign/zero-extension and merging for loads;
  - alignment exceptions.
- Stalls the pipeline while an access is in flight; supports configurable RAM wait states.

---
 rtl/mem_access_unit_pkg.sv | 58 +++++
 rtl/mem_lane_fmt.sv | 95 +++++++++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-RAM access unit.
// Op codes, exception codes, FSM states and alignment helpers.
package mem_access_unit_pkg;

    typedef logic [31:0] data_addr_bus_t;
    typedef logic [31:0] data_bus_t;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic TRUE         = 1'b1;
    localparam logic FALSE        = 1'b0;

    localparam logic [3:0] MEM_OP_NOP = 4'd0;
    localparam logic [3:0] MEM_OP_LB  = 4'd1;
    localparam logic [3:0] MEM_OP_LBU = 4'd2;
    localparam logic [3:0] MEM_OP_LH  = 4'd3;
    localparam logic [3:0] MEM_OP_LHU = 4'd4;
    localparam logic [3:0] MEM_OP_LW  = 4'd5;
    localparam logic [3:0] MEM_OP_LWL = 4'd6;
    localparam logic [3:0] MEM_OP_LWR = 4'd7;
    localparam logic [3:0] MEM_OP_SB  = 4'd8;
    localparam logic [3:0] MEM_OP_SH  = 4'd9;
    localparam logic [3:0] MEM_OP_SW  = 4'd10;
    localparam logic [3:0] MEM_OP_SWL = 4'd11;
    localparam logic [3:0] MEM_OP_SWR = 4'd12;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Codes above SWR are undefined and behave like NOP.
    function automatic logic op_valid(input logic [3:0] op);
        return (op != MEM_OP_NOP) && (op <= MEM_OP_SWR);
    endfunction

    // Halfword/word accesses must be naturally aligned.
    function automatic logic [1:0] align_exc(input logic [3:0] op,
                                             input logic [1:0] off);
        logic [1:0] e;
        e = EXC_NONE;
        if ((op == MEM_OP_LH || op == MEM_OP_LHU) && off[0])
            e = EXC_ADEL;
        if (op == MEM_OP_LW && off != 2'b00)
            e = EXC_ADEL;
        if (op == MEM_OP_SH && off[0])
            e = EXC_ADES;
        if (op == MEM_OP_SW && off != 2'b00)
            e = EXC_ADES;
        return e;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Big-endian byte-lane steering for stores and
// extract/extend/merge formatting for loads.
module mem_lane_fmt
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] rt,
    input  logic [31:0] mem_rdata,
    output logic        we,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [4:0]  sh;
    logic [4:0]  shr;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // sh = 8*off, shr = 8*(3-off); off 0 is the top lane.
    assign sh     = {off, 3'b000};
    assign shr    = {~off, 3'b000};
    assign byte_v = 8'(mem_rdata >> shr);
    assign half_v = off[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    // Decode the op into lane enables, write data and load result.
    always_comb begin
        we    = FALSE;
        sel   = 4'b0000;
        wdata = '0;
        rdata = '0;
        unique case (op)
            MEM_OP_LB: begin
                sel   = 4'b1111;
                rdata = {{24{byte_v[7]}}, byte_v};
            end
            MEM_OP_LBU: begin
                sel   = 4'b1111;
                rdata = {24'b0, byte_v};
            end
            MEM_OP_LH: begin
                sel   = 4'b1111;
                rdata = {{16{half_v[15]}}, half_v};
            end
            MEM_OP_LHU: begin
                sel   = 4'b1111;
                rdata = {16'b0, half_v};
            end
            MEM_OP_LW: begin
                sel   = 4'b1111;
                rdata = mem_rdata;
            end
            MEM_OP_LWL: begin
                sel   = 4'b1111;
                rdata = (mem_rdata << sh)
                      | (rt & ~(32'hFFFF_FFFF << sh));
            end
            MEM_OP_LWR: begin
                sel   = 4'b1111;
                rdata = (mem_rdata >> shr)
                      | (rt & ~(32'hFFFF_FFFF >> shr));
            end
            MEM_OP_SB: begin
                we    = TRUE;
                sel   = 4'b1000 >> off;
                wdata = {4{rt[7:0]}};
            end
            MEM_OP_SH: begin
                we    = TRUE;
                sel   = off[1] ? 4'b0011 : 4'b1100;
                wdata = {2{rt[15:0]}};
            end
            MEM_OP_SW: begin
                we    = TRUE;
                sel   = 4'b1111;
                wdata = rt;
            end
            MEM_OP_SWL: begin
                we    = TRUE;
                sel   = 4'b1111 >> off;
                wdata = rt >> sh;
            end
            MEM_OP_SWR: begin
                we    = TRUE;
                sel   = 4'b1111 << (~off);
                wdata = rt << shr;
            end
            default: begin
                we    = FALSE;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the data RAM: one request per
// handshake, IDLE -> ACCESS (1+WAIT_CYCLES) -> RESP.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_rt,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_exc,
    output logic [31:0] resp_badvaddr,
    output logic        stall_req,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     op_q, op_d;
    data_addr_bus_t addr_q, addr_d;
    data_bus_t      rt_q, rt_d;
    data_bus_t      rdata_q, rdata_d;
    logic [1:0]     exc_q, exc_d;
    data_addr_bus_t bad_q, bad_d;

    logic           accept;
    logic [1:0]     req_exc;
    logic           f_we;
    logic [3:0]     f_sel;
    data_bus_t      f_wdata;
    data_bus_t      f_rdata;

    assign accept  = req_valid & op_valid(req_op);
    assign req_exc = align_exc(req_op, req_addr[1:0]);

    mem_lane_fmt u_fmt (
        .op        (op_q),
        .off       (addr_q[1:0]),
        .rt        (rt_q),
        .mem_rdata (mem_data_i),
        .we        (f_we),
        .sel       (f_sel),
        .wdata     (f_wdata),
        .rdata     (f_rdata)
    );

    // State and transaction registers; reset abandons any access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MEM_OP_NOP;
            addr_q  <= '0;
            rt_q    <= '0;
            rdata_q <= '0;
            exc_q   <= EXC_NONE;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rt_q    <= rt_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
            bad_q   <= bad_d;
        end
    end

    // Next-state logic and all port outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        addr_d        = addr_q;
        rt_d          = rt_q;
        rdata_d       = rdata_q;
        exc_d         = exc_q;
        bad_d         = bad_q;
        req_ready     = FALSE;
        stall_req     = FALSE;
        resp_valid    = FALSE;
        resp_rdata    = '0;
        resp_exc      = EXC_NONE;
        resp_badvaddr = '0;
        mem_ce        = CHIP_DISABLE;
        mem_we        = FALSE;
        mem_addr      = '0;
        mem_sel       = 4'b0000;
        mem_data_o    = '0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = TRUE;
                stall_req = accept;
                if (accept) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    rt_d    = req_rt;
                    rdata_d = '0;
                    exc_d   = req_exc;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (req_exc != EXC_NONE) begin
                        bad_d   = req_addr;
                        state_d = ST_RESP;
                    end else begin
                        bad_d   = '0;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                stall_req  = TRUE;
                mem_ce     = CHIP_ENABLE;
                mem_we     = f_we;
                mem_addr   = {addr_q[31:2], 2'b00};
                mem_sel    = f_sel;
                mem_data_o = f_wdata;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = f_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid    = TRUE;
                resp_rdata    = rdata_q;
                resp_exc      = exc_q;
                resp_badvaddr = bad_q;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (WAIT 0 and 2)
// sharing a RAM, checked against a byte-array memory model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid [2];
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_rt;
    logic        req_ready [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic [1:0]  resp_exc [2];
    logic [31:0] resp_badvaddr [2];
    logic        stall_req [2];
    logic        mem_ce [2];
    logic        mem_we [2];
    logic [31:0] mem_addr [2];
    logic [3:0]  mem_sel [2];
    logic [31:0] mem_data_o [2];
    logic [31:0] mem_data_i0, mem_data_i1;

    logic [31:0] ram [128];
    logic [7:0]  mb [512];

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op), .req_addr(req_addr), .req_rt(req_rt),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .resp_exc(resp_exc[0]), .resp_badvaddr(resp_badvaddr[0]),
        .stall_req(stall_req[0]), .mem_ce(mem_ce[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_sel(mem_sel[0]), .mem_data_o(mem_data_o[0]),
        .mem_data_i(mem_data_i0)
    );

    mem_access_unit #(.WAIT_CYCLES(2)) u2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op), .req_addr(req_addr), .req_rt(req_rt),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .resp_exc(resp_exc[1]), .resp_badvaddr(resp_badvaddr[1]),
        .stall_req(stall_req[1]), .mem_ce(mem_ce[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_sel(mem_sel[1]), .mem_data_o(mem_data_o[1]),
        .mem_data_i(mem_data_i1)
    );

    assign mem_data_i0 = ram[mem_addr[0][8:2]];
    assign mem_data_i1 = ram[mem_addr[1][8:2]];

    // RAM: byte-enabled write on any enabled write cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (mem_ce[i] && mem_we[i])
                for (int b = 0; b < 4; b++)
                    if (mem_sel[i][b])
                        ram[mem_addr[i][8:2]][8*b +: 8] = mem_data_o[i][8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_store(input logic [3:0] op);
        return op >= MEM_OP_SB && op <= MEM_OP_SWR;
    endfunction

    function automatic logic [1:0] m_exc(input logic [3:0] op, input int a);
        if ((op == MEM_OP_LH || op == MEM_OP_LHU) && (a % 2) != 0) return EXC_ADEL;
        if (op == MEM_OP_LW && (a % 4) != 0) return EXC_ADEL;
        if (op == MEM_OP_SH && (a % 2) != 0) return EXC_ADES;
        if (op == MEM_OP_SW && (a % 4) != 0) return EXC_ADES;
        return EXC_NONE;
    endfunction

    // Loads from the byte memory: byte a is most significant within its word.
    function automatic logic [31:0] m_load(input logic [3:0] op, input int a,
                                           input logic [31:0] rt);
        logic [31:0] r;
        int off;
        off = a % 4;
        r = 32'h0;
        case (op)
            MEM_OP_LB:  r = {{24{mb[a][7]}}, mb[a]};
            MEM_OP_LBU: r = {24'h0, mb[a]};
            MEM_OP_LH:  r = {{16{mb[a][7]}}, mb[a], mb[a+1]};
            MEM_OP_LHU: r = {16'h0, mb[a], mb[a+1]};
            MEM_OP_LW:  r = {mb[a], mb[a+1], mb[a+2], mb[a+3]};
            MEM_OP_LWL: begin
                r = rt;
                for (int k = 0; k <= 3 - off; k++) r[8*(3-k) +: 8] = mb[a+k];
            end
            MEM_OP_LWR: begin
                r = rt;
                for (int k = 0; k <= off; k++) r[8*k +: 8] = mb[a-k];
            end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic m_store(input logic [3:0] op, input int a,
                           input logic [31:0] rt);
        int off;
        off = a % 4;
        case (op)
            MEM_OP_SB: mb[a] = rt[7:0];
            MEM_OP_SH: begin mb[a] = rt[15:8]; mb[a+1] = rt[7:0]; end
            MEM_OP_SW: for (int k = 0; k < 4; k++) mb[a+k] = rt[8*(3-k) +: 8];
            MEM_OP_SWL: for (int k = 0; k <= 3 - off; k++) mb[a+k] = rt[8*(3-k) +: 8];
            MEM_OP_SWR: for (int k = 0; k <= off; k++) mb[a-k] = rt[8*k +: 8];
            default: ;
        endcase
    endtask

    int          r_lat, r_ce_n;
    logic        r_got, r_stable, r_stall_acc;
    logic        r_ready_idle, r_stall_idle, r_resp_ready, r_resp_stall;
    logic [31:0] r_rdata, r_bad, r_acc_addr, r_acc_data;
    logic [1:0]  r_exc;
    logic [3:0]  r_acc_sel;
    logic        r_acc_we;

    // Issue one request on instance d and observe it to completion.
    task automatic do_req(input int d, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] rt);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1; req_op = op; req_addr = a; req_rt = rt;
        #1;
        r_ready_idle = req_ready[d];
        r_stall_idle = stall_req[d];
        @(posedge clk); #1;
        req_valid[d] = 1'b0; req_op = MEM_OP_NOP;
        n = 1; r_ce_n = 0; r_stable = 1'b1; r_stall_acc = 1'b1; r_got = 1'b0;
        r_lat = 0;
        while (n <= 24 && !r_got) begin
            if (resp_valid[d]) begin
                r_got = 1'b1; r_lat = n;
                r_rdata = resp_rdata[d]; r_exc = resp_exc[d];
                r_bad = resp_badvaddr[d];
                r_resp_ready = req_ready[d]; r_resp_stall = stall_req[d];
            end else begin
                if (mem_ce[d]) begin
                    if (r_ce_n == 0) begin
                        r_acc_addr = mem_addr[d]; r_acc_sel = mem_sel[d];
                        r_acc_data = mem_data_o[d]; r_acc_we = mem_we[d];
                    end else if (mem_addr[d] !== r_acc_addr || mem_sel[d] !== r_acc_sel
                                 || mem_data_o[d] !== r_acc_data || mem_we[d] !== r_acc_we)
                        r_stable = 1'b0;
                    if (!stall_req[d]) r_stall_acc = 1'b0;
                    r_ce_n++;
                end
                @(posedge clk); #1;
                n++;
            end
        end
        chk("resp_seen", {31'b0, r_got}, 32'd1);
        @(posedge clk); #1;
        chk("resp_pulse_one_cycle", {31'b0, resp_valid[d]}, 32'd0);
    endtask

    // Request checked entirely against the model, model updated on stores.
    task automatic run_check(input int d, input logic [3:0] op,
                             input int a, input logic [31:0] rt);
        logic [1:0]  e;
        logic [31:0] exp_rd;
        int w;
        w = (d == 0) ? 0 : 2;
        e = m_exc(op, a);
        exp_rd = (e == EXC_NONE) ? m_load(op, a, rt) : 32'h0;
        do_req(d, op, 32'(a), rt);
        chk($sformatf("rdata op%0d a%0h", op, a), r_rdata, exp_rd);
        chk($sformatf("exc op%0d a%0h", op, a), {30'b0, r_exc}, {30'b0, e});
        chk($sformatf("bad op%0d a%0h", op, a), r_bad,
            (e == EXC_NONE) ? 32'h0 : 32'(a));
        chk($sformatf("lat op%0d w%0d", op, w), r_lat,
            (e == EXC_NONE) ? 2 + w : 1);
        chk($sformatf("ce_n op%0d w%0d", op, w), r_ce_n,
            (e == EXC_NONE) ? 1 + w : 0);
        if (e == EXC_NONE && is_store(op)) m_store(op, a, rt);
    endtask

    // Undefined/NOP codes must not be accepted.
    task automatic idle_req(input int d, input logic [3:0] op);
        @(negedge clk);
        req_valid[d] = 1'b1; req_op = op; req_addr = $urandom; req_rt = $urandom;
        #1;
        chk("nop_stall", {31'b0, stall_req[d]}, 32'd0);
        @(posedge clk); #1;
        req_valid[d] = 1'b0; req_op = MEM_OP_NOP;
        chk("nop_ce", {31'b0, mem_ce[d]}, 32'd0);
        @(posedge clk); #1;
        chk("nop_resp", {31'b0, resp_valid[d]}, 32'd0);
    endtask

    initial begin
        logic        saw_resp;
        logic [3:0]  op;
        int          a, d;
        for (int w = 0; w < 128; w++) begin
            ram[w] = $urandom;
            for (int k = 0; k < 4; k++) mb[4*w+k] = ram[w][8*(3-k) +: 8];
        end
        rst = 1'b0;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        req_op = MEM_OP_NOP; req_addr = 32'h0; req_rt = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", {31'b0, req_ready[i]}, 32'd1);
            chk("rst_resp", {31'b0, resp_valid[i]}, 32'd0);
            chk("rst_ce_we_stall", {29'b0, mem_ce[i], mem_we[i], stall_req[i]}, 32'd0);
            chk("rst_addr_sel", mem_addr[i] | {28'b0, mem_sel[i]}, 32'd0);
            chk("rst_data_rdata", mem_data_o[i] | resp_rdata[i], 32'd0);
            chk("rst_exc_bad", resp_badvaddr[i] | {30'b0, resp_exc[i]}, 32'd0);
        end
        @(negedge clk); rst = 1'b1;

        // SB lane steering
        do_req(0, MEM_OP_SB, 32'h101, 32'h0000_00AB);
        m_store(MEM_OP_SB, 'h101, 32'h0000_00AB);
        chk("sb_ready_idle", {31'b0, r_ready_idle}, 32'd1);
        chk("sb_stall_idle", {31'b0, r_stall_idle}, 32'd1);
        chk("sb_addr", r_acc_addr, 32'h100);
        chk("sb_sel", {28'b0, r_acc_sel}, 32'b0100);
        chk("sb_data", r_acc_data, 32'hABAB_ABAB);
        chk("sb_we", {31'b0, r_acc_we}, 32'd1);
        chk("sb_lat", r_lat, 2);
        chk("sb_rdata", r_rdata, 32'h0);
        chk("sb_resp_ready", {31'b0, r_resp_ready}, 32'd0);
        chk("sb_resp_stall", {31'b0, r_resp_stall}, 32'd0);
        chk("sb_ram", ram[64], {mb[256], mb[257], mb[258], mb[259]});

        // Loads of 0x1280FF34 at 0x40
        run_check(0, MEM_OP_SW, 'h40, 32'h1280_FF34);
        do_req(0, MEM_OP_LB, 32'h42, 32'h0);
        chk("lb", r_rdata, 32'hFFFF_FFFF);
        do_req(0, MEM_OP_LBU, 32'h42, 32'h0);
        chk("lbu", r_rdata, 32'h0000_00FF);
        do_req(0, MEM_OP_LH, 32'h40, 32'h0);
        chk("lh", r_rdata, 32'h0000_1280);
        do_req(0, MEM_OP_LHU, 32'h42, 32'h0);
        chk("lhu", r_rdata, 32'h0000_FF34);
        do_req(0, MEM_OP_LWL, 32'h41, 32'hAABB_CCDD);
        chk("lwl", r_rdata, 32'h80FF_34DD);
        do_req(0, MEM_OP_LWR, 32'h41, 32'hAABB_CCDD);
        chk("lwr", r_rdata, 32'hAABB_1280);
        do_req(0, MEM_OP_SWL, 32'h42, 32'h1122_3344);
        m_store(MEM_OP_SWL, 'h42, 32'h1122_3344);
        chk("swl_sel", {28'b0, r_acc_sel}, 32'b0011);
        chk("swl_data", r_acc_data, 32'h0000_1122);

        // Alignment exceptions
        do_req(0, MEM_OP_LW, 32'h43, 32'h0);
        chk("lw_mis_exc", {30'b0, r_exc}, {30'b0, EXC_ADEL});
        chk("lw_mis_bad", r_bad, 32'h43);
        chk("lw_mis_ce", r_ce_n, 0);
        chk("lw_mis_lat", r_lat, 1);
        do_req(0, MEM_OP_SH, 32'h45, 32'h0);
        chk("sh_mis_exc", {30'b0, r_exc}, {30'b0, EXC_ADES});
        chk("sh_mis_bad", r_bad, 32'h45);

        // Wait states
        do_req(1, MEM_OP_LW, 32'h40, 32'h0);
        chk("w2_ce_cycles", r_ce_n, 3);
        chk("w2_stable", {31'b0, r_stable}, 32'd1);
        chk("w2_stall", {31'b0, r_stall_acc}, 32'd1);
        chk("w2_lat", r_lat, 4);
        chk("w2_rdata", r_rdata, 32'h1280_1122);

        // Reset in the middle of an access
        @(negedge clk);
        req_valid[1] = 1'b1; req_op = MEM_OP_LW; req_addr = 32'h80;
        @(posedge clk); #1;
        req_valid[1] = 1'b0; req_op = MEM_OP_NOP;
        chk("abort_ce_before", {31'b0, mem_ce[1]}, 32'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", {31'b0, req_ready[1]}, 32'd1);
        chk("abort_ctl", {28'b0, mem_ce[1], mem_we[1], stall_req[1], resp_valid[1]}, 32'd0);
        chk("abort_bus", mem_addr[1] | mem_data_o[1] | {28'b0, mem_sel[1]}, 32'd0);
        @(negedge clk); rst = 1'b1;
        saw_resp = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid[1]) saw_resp = 1'b1;
        end
        chk("abort_no_resp", {31'b0, saw_resp}, 32'd0);
        run_check(1, MEM_OP_SW, 'h80, 32'hDEAD_BEEF);
        run_check(1, MEM_OP_LW, 'h80, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            d  = int'($urandom_range(0, 1));
            a  = int'($urandom_range(0, 511));
            if (op == MEM_OP_NOP || op > MEM_OP_SWR)
                idle_req(d, op);
            else
                run_check(d, op, a, $urandom);
        end

        for (int w = 0; w < 128; w++)
            chk($sformatf("ram_word_%0d", w), ram[w],
                {mb[4*w], mb[4*w+1], mb[4*w+2], mb[4*w+3]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
